// File: rtl/audio_pkg.sv
// Shared definitions for the audio PWM path (transmitter and capture).
// Holds sample/address widths, default frame timing, the capture state
// encoding and the sample saturation helper.
package audio_pkg;

    localparam int SAMPLE_W     = 11;
    localparam int ADDR_W       = 8;
    localparam int FRAME_LEN    = 2048;
    localparam int SYNC_TIMEOUT = 4096;
    localparam int SAMPLE_MAX   = (1 << SAMPLE_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // A full-high frame counts FRAME_LEN cycles, which does not fit in the
    // sample width, so clamp it to the largest representable sample.
    function automatic logic [SAMPLE_W-1:0] saturate_sample(input logic [31:0] count);
        if (count > 32'(SAMPLE_MAX)) begin
            return SAMPLE_W'(SAMPLE_MAX);
        end
        return count[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector working on the synchronized value.
module sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic synced,
    output logic rise
);

    logic meta;
    logic synced_q;
    logic prev;

    // Metastability chain plus one extra stage holding the previous synced level.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            synced_q <= 1'b0;
            prev     <= 1'b0;
        end else begin
            meta     <= raw;
            synced_q <= meta;
            prev     <= synced_q;
        end
    end

    assign synced = synced_q;
    assign rise   = synced_q & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: locks onto the first rising edge of an incoming PWM stream,
// then measures the high time of consecutive fixed-length frames and writes
// one saturated sample per frame into a sample memory.
module pwm_capture
    import audio_pkg::*;
#(
    parameter int FRAME_LEN    = audio_pkg::FRAME_LEN,
    parameter int DEPTH        = 256,
    parameter int SYNC_TIMEOUT = audio_pkg::SYNC_TIMEOUT
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  logic                pwm_in,
    input  logic                arm,
    output logic [ADDR_W-1:0]   addra,
    output logic [SAMPLE_W-1:0] dina,
    output logic                wea,
    output logic                busy,
    output logic                done,
    output logic                no_signal
);

    localparam int WIN_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int TO_W  = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SYNC_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    cap_state_t       state;
    cap_state_t       next_state;
    logic             pwm_s;
    logic             pwm_rise;
    logic [WIN_W-1:0] win_idx;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_sum;
    logic [TO_W-1:0]  timeout_cnt;
    logic             start;
    logic             lock;
    logic             timeout;
    logic             window_end;

    sync_edge u_sync_edge (
        .clock   (CLK100MHZ),
        .reset_n (CPU_RESETN),
        .raw     (pwm_in),
        .synced  (pwm_s),
        .rise    (pwm_rise)
    );

    // High count including the current cycle's synchronized level.
    always_comb begin
        high_sum = high_cnt + CNT_W'(pwm_s);
    end

    // State register; reset drops any run in progress back to IDLE.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the one-cycle control strobes for the datapath.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        lock       = 1'b0;
        timeout    = 1'b0;
        window_end = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    next_state = ST_SYNC;
                    start      = 1'b1;
                end
            end
            ST_SYNC: begin
                if (pwm_rise) begin
                    next_state = ST_CAPTURE;
                    lock       = 1'b1;
                end else if (timeout_cnt == TO_LAST) begin
                    next_state = ST_IDLE;
                    timeout    = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (win_idx == WIN_LAST) begin
                    window_end = 1'b1;
                end
                if (wea && (addra == ADDR_LAST)) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Window/high counters, sync timeout, sample write port and sticky flag.
    // The lock cycle is window index 0 and is already known to be high, so
    // both counters start at 1. Windows run back to back with no gap.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            addra       <= '0;
            dina        <= '0;
            wea         <= 1'b0;
            no_signal   <= 1'b0;
            win_idx     <= '0;
            high_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            wea  <= 1'b0;
            dina <= '0;

            if (start) begin
                addra       <= '0;
                no_signal   <= 1'b0;
                timeout_cnt <= '0;
            end

            if ((state == ST_SYNC) && !pwm_rise) begin
                timeout_cnt <= timeout_cnt + TO_W'(1);
            end

            if (timeout) begin
                no_signal <= 1'b1;
            end

            if (lock) begin
                win_idx  <= WIN_W'(1);
                high_cnt <= CNT_W'(1);
            end

            if (state == ST_CAPTURE) begin
                if (window_end) begin
                    win_idx  <= '0;
                    high_cnt <= '0;
                    wea      <= 1'b1;
                    dina     <= saturate_sample(32'(high_sum));
                end else begin
                    win_idx  <= win_idx + WIN_W'(1);
                    high_cnt <= high_sum;
                end
                if (wea) begin
                    addra <= (addra == ADDR_LAST) ? '0 : addra + ADDR_W'(1);
                end
            end
        end
    end

    assign busy = (state == ST_SYNC) || (state == ST_CAPTURE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture. A reduced-size instance (short frames,
// small depth) covers the run sequencing; a default-size instance covers
// saturation, full-length frames and the real sync timeout.
module tb_pwm_capture;

    localparam int S_FL    = 16;
    localparam int S_DEPTH = 8;
    localparam int S_TO    = 64;
    localparam int L_FL    = 2048;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn_s, pwm_in_s, arm_s;
    logic [7:0]  addra_s;
    logic [10:0] dina_s;
    logic        wea_s, busy_s, done_s, nosig_s;

    logic        rstn_l, pwm_in_l, arm_l;
    logic [7:0]  addra_l;
    logic [10:0] dina_l;
    logic        wea_l, busy_l, done_l, nosig_l;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int wr_addr_s [$];
    int wr_data_s [$];
    int wr_cyc_s  [$];
    int wr_addr_l [$];
    int wr_data_l [$];
    int wr_cyc_l  [$];

    int sine_tbl [8] = '{8, 13, 16, 13, 8, 3, 0, 3};

    pwm_capture #(.FRAME_LEN(S_FL), .DEPTH(S_DEPTH), .SYNC_TIMEOUT(S_TO)) dut_s (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn_s),
        .pwm_in     (pwm_in_s),
        .arm        (arm_s),
        .addra      (addra_s),
        .dina       (dina_s),
        .wea        (wea_s),
        .busy       (busy_s),
        .done       (done_s),
        .no_signal  (nosig_s)
    );

    pwm_capture dut_l (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rstn_l),
        .pwm_in     (pwm_in_l),
        .arm        (arm_l),
        .addra      (addra_l),
        .dina       (dina_l),
        .wea        (wea_l),
        .busy       (busy_l),
        .done       (done_l),
        .no_signal  (nosig_l)
    );

    // Record every memory write of both instances, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wea_s) begin
            wr_addr_s.push_back(int'(addra_s));
            wr_data_s.push_back(int'(dina_s));
            wr_cyc_s.push_back(cyc);
        end
        if (wea_l) begin
            wr_addr_l.push_back(int'(addra_l));
            wr_data_l.push_back(int'(dina_l));
            wr_cyc_l.push_back(cyc);
        end
    end

    task automatic clear_logs();
        wr_addr_s.delete(); wr_data_s.delete(); wr_cyc_s.delete();
        wr_addr_l.delete(); wr_data_l.delete(); wr_cyc_l.delete();
    endtask

    task automatic start_s();
        @(negedge clk); pwm_in_s = 1'b0; arm_s = 1'b1;
        @(negedge clk); arm_s = 1'b0;
    endtask

    task automatic start_l();
        @(negedge clk); pwm_in_l = 1'b0; arm_l = 1'b1;
        @(negedge clk); arm_l = 1'b0;
    endtask

    // One small-instance frame; arm is pulsed at cycle arm_at (-1 for never).
    task automatic frame_s(input int duty, input int arm_at);
        for (int c = 0; c < S_FL; c++) begin
            @(negedge clk);
            pwm_in_s = (c < duty);
            arm_s    = (c == arm_at);
        end
        @(negedge clk); arm_s = 1'b0; pwm_in_s = 1'b0;
        pwm_in_s = 1'b0;
    endtask

    task automatic frame_l(input int duty);
        for (int c = 0; c < L_FL; c++) begin
            @(negedge clk);
            pwm_in_l = (c < duty);
        end
    endtask

    task automatic flush(input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in_s = 1'b0;
            pwm_in_l = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn_s = 1'b0; rstn_l = 1'b0;
        arm_s = 1'b0; arm_l = 1'b0;
        pwm_in_s = 1'b0; pwm_in_l = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({addra_s, dina_s, wea_s, busy_s, done_s, nosig_s} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_small: got %h expected 0", {addra_s, dina_s, wea_s, busy_s, done_s, nosig_s});
        end
        checks++;
        if ({addra_l, dina_l, wea_l, busy_l, done_l, nosig_l} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_large: got %h expected 0", {addra_l, dina_l, wea_l, busy_l, done_l, nosig_l});
        end
        rstn_s = 1'b1; rstn_l = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_s, done_s, wea_s, busy_l, done_l, wea_l} !== 6'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected 000000", {busy_s, done_s, wea_s, busy_l, done_l, wea_l});
        end
    endtask

    // Half duty for DEPTH frames: DEPTH writes, sequential addresses, no gaps.
    task automatic test_half_duty();
        clear_logs();
        start_s();
        checks++;
        if (busy_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_in_sync: got %b expected 1", busy_s);
        end
        for (int f = 0; f < S_DEPTH; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < 8);
            end
        end
        flush(8);
        checks++;
        if (wr_data_s.size() != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL half_write_count: got %0d expected %0d", wr_data_s.size(), S_DEPTH);
        end
        for (int i = 0; i < wr_data_s.size(); i++) begin
            checks++;
            if (wr_data_s[i] != 8 || wr_addr_s[i] != i) begin
                errors++;
                $display("[TB] FAIL half_sample%0d: got addr %0d data %0d expected addr %0d data 8", i, wr_addr_s[i], wr_data_s[i], i);
            end
            if (i > 0) begin
                checks++;
                if (wr_cyc_s[i] - wr_cyc_s[i-1] != S_FL) begin
                    errors++;
                    $display("[TB] FAIL half_spacing%0d: got %0d expected %0d", i, wr_cyc_s[i] - wr_cyc_s[i-1], S_FL);
                end
            end
        end
        checks++;
        if ({done_s, busy_s, addra_s} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL half_done_state: got done %b busy %b addra %0d expected 1 0 0", done_s, busy_s, addra_s);
        end
    endtask

    // Alternating near-full and minimal duty frames.
    task automatic test_alternate_small();
        clear_logs();
        start_s();
        for (int f = 0; f < S_DEPTH; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < (((f % 2) == 0) ? 15 : 1));
            end
        end
        flush(8);
        checks++;
        if (wr_data_s.size() != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL alt_write_count: got %0d expected %0d", wr_data_s.size(), S_DEPTH);
        end
        for (int i = 0; i < wr_data_s.size(); i++) begin
            checks++;
            if (wr_data_s[i] != (((i % 2) == 0) ? 15 : 1)) begin
                errors++;
                $display("[TB] FAIL alt_sample%0d: got %0d expected %0d", i, wr_data_s[i], ((i % 2) == 0) ? 15 : 1);
            end
        end
    endtask

    // Arm pulses during capture must not restart the address sequence.
    task automatic test_arm_ignored();
        clear_logs();
        start_s();
        for (int f = 0; f < S_DEPTH; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < 5);
                arm_s    = ((f == 3) && (c == 7)) || ((f == 5) && (c == 2));
            end
        end
        arm_s = 1'b0;
        flush(8);
        checks++;
        if (wr_data_s.size() != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL arm_ign_write_count: got %0d expected %0d", wr_data_s.size(), S_DEPTH);
        end
        for (int i = 0; i < wr_data_s.size(); i++) begin
            checks++;
            if (wr_addr_s[i] != i || wr_data_s[i] != 5) begin
                errors++;
                $display("[TB] FAIL arm_ign_sample%0d: got addr %0d data %0d expected addr %0d data 5", i, wr_addr_s[i], wr_data_s[i], i);
            end
        end
        checks++;
        if (done_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arm_ign_done: got %b expected 1", done_s);
        end
    endtask

    // One-cycle reset in the middle of sample 3 aborts the run; re-arm restarts at 0.
    task automatic test_reset_mid_capture();
        clear_logs();
        start_s();
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < 6);
                rstn_s   = !((f == 3) && (c == 8));
                if ((f == 3) && (c == 9)) begin
                    checks++;
                    if ({addra_s, dina_s, wea_s, busy_s, done_s, nosig_s} !== 23'd0) begin
                        errors++;
                        $display("[TB] FAIL midreset_outputs: got %h expected 0", {addra_s, dina_s, wea_s, busy_s, done_s, nosig_s});
                    end
                end
            end
        end
        flush(8);
        checks++;
        if (wr_data_s.size() != 3) begin
            errors++;
            $display("[TB] FAIL midreset_write_count: got %0d expected 3", wr_data_s.size());
        end
        clear_logs();
        start_s();
        for (int f = 0; f < S_DEPTH; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < 6);
            end
        end
        flush(8);
        checks++;
        if (wr_addr_s.size() != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL rearm_write_count: got %0d expected %0d", wr_addr_s.size(), S_DEPTH);
        end else begin
            checks++;
            if (wr_addr_s[0] != 0 || wr_addr_s[S_DEPTH-1] != S_DEPTH - 1 || wr_data_s[0] != 6) begin
                errors++;
                $display("[TB] FAIL rearm_sequence: got first addr %0d last addr %0d data %0d expected 0 %0d 6", wr_addr_s[0], wr_addr_s[S_DEPTH-1], wr_data_s[0], S_DEPTH - 1);
            end
        end
    endtask

    // A table of duties (including empty and full frames) is returned unchanged.
    task automatic test_table_loopback();
        clear_logs();
        start_s();
        for (int f = 0; f < S_DEPTH; f++) begin
            for (int c = 0; c < S_FL; c++) begin
                @(negedge clk);
                pwm_in_s = (c < sine_tbl[f]);
            end
        end
        flush(8);
        checks++;
        if (wr_data_s.size() != S_DEPTH) begin
            errors++;
            $display("[TB] FAIL table_write_count: got %0d expected %0d", wr_data_s.size(), S_DEPTH);
        end
        for (int i = 0; i < wr_data_s.size(); i++) begin
            checks++;
            if (wr_data_s[i] != sine_tbl[i]) begin
                errors++;
                $display("[TB] FAIL table_sample%0d: got %0d expected %0d", i, wr_data_s[i], sine_tbl[i]);
            end
        end
    endtask

    // Constant high after lock gives a 2048 count, stored as 2047.
    task automatic test_saturation();
        int n;
        clear_logs();
        start_l();
        @(negedge clk); pwm_in_l = 1'b1;
        n = 0;
        while (wr_data_l.size() < 2 && n < 3 * L_FL + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_data_l.size() < 2) begin
            errors++;
            $display("[TB] FAIL sat_timeout: got %0d writes expected 2", wr_data_l.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wr_data_l[i] != 2047 || wr_addr_l[i] != i) begin
                    errors++;
                    $display("[TB] FAIL sat_sample%0d: got addr %0d data %0d expected addr %0d data 2047", i, wr_addr_l[i], wr_data_l[i], i);
                end
            end
        end
        @(negedge clk); rstn_l = 1'b0; pwm_in_l = 1'b0;
        @(negedge clk); rstn_l = 1'b1;
        checks++;
        if ({addra_l, dina_l, wea_l, busy_l, done_l, nosig_l} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL sat_reset: got %h expected 0", {addra_l, dina_l, wea_l, busy_l, done_l, nosig_l});
        end
    endtask

    // Full-length frames alternating duty 2047 and 1.
    task automatic test_alternate_large();
        clear_logs();
        start_l();
        frame_l(2047);
        frame_l(1);
        frame_l(2047);
        frame_l(1);
        flush(8);
        checks++;
        if (wr_data_l.size() != 4) begin
            errors++;
            $display("[TB] FAIL altl_write_count: got %0d expected 4", wr_data_l.size());
        end
        for (int i = 0; i < wr_data_l.size(); i++) begin
            checks++;
            if (wr_data_l[i] != (((i % 2) == 0) ? 2047 : 1)) begin
                errors++;
                $display("[TB] FAIL altl_sample%0d: got %0d expected %0d", i, wr_data_l[i], ((i % 2) == 0) ? 2047 : 1);
            end
            if (i > 0) begin
                checks++;
                if (wr_cyc_l[i] - wr_cyc_l[i-1] != L_FL) begin
                    errors++;
                    $display("[TB] FAIL altl_spacing%0d: got %0d expected %0d", i, wr_cyc_l[i] - wr_cyc_l[i-1], L_FL);
                end
            end
        end
        @(negedge clk); rstn_l = 1'b0;
        @(negedge clk); rstn_l = 1'b1;
    endtask

    // Arm with no PWM: no_signal appears exactly 4096 clocks after SYNC entry.
    task automatic test_timeout();
        int n;
        clear_logs();
        start_l();
        checks++;
        if (busy_l !== 1'b1 || nosig_l !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_sync_entry: got busy %b no_signal %b expected 1 0", busy_l, nosig_l);
        end
        n = 0;
        while (nosig_l !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4096) begin
            errors++;
            $display("[TB] FAIL to_latency: got %0d expected 4096", n);
        end
        checks++;
        if ({nosig_l, busy_l, done_l} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL to_state: got no_signal %b busy %b done %b expected 1 0 0", nosig_l, busy_l, done_l);
        end
        checks++;
        if (wr_data_l.size() != 0) begin
            errors++;
            $display("[TB] FAIL to_no_write: got %0d writes expected 0", wr_data_l.size());
        end
    endtask

    initial begin
        $display("[TB] starting pwm_capture bench");
        test_reset();
        test_half_duty();
        test_alternate_small();
        test_arm_ignored();
        test_reset_mid_capture();
        test_table_loopback();
        test_saturation();
        test_alternate_large();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
